// File: rtl/rk_sd_bridge_pkg.sv
// Shared types and status codes for the RK11 to SD command bridge.
// Error codes are also decoded by the RK11 status logic.
package rk_sd_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_ACCEPT = 3'd2,
        ST_XFER   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [7:0] ERR_BOTH    = 8'hE1;
    localparam logic [7:0] ERR_BUSY    = 8'hE2;
    localparam logic [7:0] ERR_ACCEPT  = 8'hE3;
    localparam logic [7:0] ERR_OVER    = 8'hE4;
    localparam logic [7:0] ERR_SHORT   = 8'hE5;
    localparam logic [7:0] ERR_TIMEOUT = 8'hE6;

    function automatic logic [31:0] make_lba(
        input logic [15:0] offset,
        input logic [2:0]  dev,
        input logic [12:0] blk
    );
        return {offset, dev, blk};
    endfunction

endpackage

// File: rtl/rk_sd_timer.sv
// Saturating down-counter: load arms it, en counts it down,
// expire is high once CYCLES enabled cycles have elapsed since load.
module rk_sd_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk20,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk20) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/rk_sd_bridge.sv
// Sequences RK11 block requests onto the SD engine and checks
// the word count and status of every block transfer.
module rk_sd_bridge #(
    parameter logic [15:0] LBA_OFFSET      = 16'h0002,
    parameter int          WORDS_PER_BLOCK = 256,
    parameter int          ACCEPT_CYCLES   = 16,
    parameter int          TIMEOUT_CYCLES  = 2000000
) (
    input  logic        clk20,
    input  logic        reset,
    input  logic [2:0]  rk_dev_sel,
    input  logic [12:0] rk_lba,
    input  logic        rk_read,
    input  logic        rk_write,
    output logic        rk_ready,
    output logic        rk_done,
    output logic        rk_error,
    output logic [7:0]  rk_err_code,
    output logic [8:0]  xfer_count,
    input  logic        sd_ready,
    input  logic [7:0]  sd_err,
    input  logic        sd_rd_strobe,
    input  logic        sd_wr_strobe,
    output logic        sd_read,
    output logic        sd_write,
    output logic [31:0] sd_lba
);

    import rk_sd_bridge_pkg::*;

    localparam logic [9:0] WPB = 10'(WORDS_PER_BLOCK);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        go_err;
    logic [7:0]  err_nxt;
    logic [7:0]  pend_code;
    logic        dir_wr;
    logic        acc_en;
    logic        acc_exp;
    logic        to_en;
    logic        to_exp;
    logic        counting;
    logic        strobe;
    logic [9:0]  count_inc;
    logic        overflow;

    assign acc_en   = (state == ST_ACCEPT);
    assign counting = (state == ST_ACCEPT) || (state == ST_XFER);
    assign to_en    = counting || (state == ST_ISSUE);

    // Only the strobe matching the latched direction is counted.
    assign strobe    = dir_wr ? sd_wr_strobe : sd_rd_strobe;
    assign count_inc = {1'b0, xfer_count} + {9'd0, strobe};
    assign overflow  = (count_inc > WPB);

    rk_sd_timer #(
        .CYCLES (ACCEPT_CYCLES)
    ) u_accept_timer (
        .clk20  (clk20),
        .reset  (reset),
        .load   (accept),
        .en     (acc_en),
        .expire (acc_exp)
    );

    rk_sd_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clk20  (clk20),
        .reset  (reset),
        .load   (accept),
        .en     (to_en),
        .expire (to_exp)
    );

    always_ff @(posedge clk20) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        go_err    = 1'b0;
        err_nxt   = 8'h00;
        unique case (state)
            ST_IDLE: begin
                if (rk_read && rk_write) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_BOTH;
                end else if (rk_read || rk_write) begin
                    if (!sd_ready) begin
                        go_err  = 1'b1;
                        err_nxt = ERR_BUSY;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (overflow) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_OVER;
                end else if (!sd_ready) begin
                    state_nxt = ST_XFER;
                end else if (acc_exp) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_ACCEPT;
                end else if (to_exp) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_XFER: begin
                // A strobe coinciding with sd_ready is already in count_inc.
                if (overflow) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_OVER;
                end else if (sd_ready) begin
                    if (sd_err != 8'h00) begin
                        go_err  = 1'b1;
                        err_nxt = sd_err;
                    end else if (count_inc != WPB) begin
                        go_err  = 1'b1;
                        err_nxt = ERR_SHORT;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (to_exp) begin
                    go_err  = 1'b1;
                    err_nxt = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (go_err) begin
            state_nxt = ST_ERROR;
        end
    end

    always_ff @(posedge clk20) begin
        if (reset) begin
            rk_ready    <= 1'b0;
            rk_done     <= 1'b0;
            rk_error    <= 1'b0;
            rk_err_code <= 8'h00;
            xfer_count  <= 9'd0;
            sd_read     <= 1'b0;
            sd_write    <= 1'b0;
            sd_lba      <= 32'd0;
            dir_wr      <= 1'b0;
            pend_code   <= 8'h00;
        end else begin
            rk_ready <= (state == ST_IDLE) && sd_ready && !accept && !go_err;
            rk_done  <= 1'b0;
            sd_read  <= 1'b0;
            sd_write <= 1'b0;
            if (accept) begin
                sd_lba      <= make_lba(LBA_OFFSET, rk_dev_sel, rk_lba);
                dir_wr      <= rk_write;
                sd_read     <= rk_read;
                sd_write    <= rk_write;
                rk_error    <= 1'b0;
                rk_err_code <= 8'h00;
                xfer_count  <= 9'd0;
            end
            if (go_err) begin
                pend_code <= err_nxt;
            end
            if (counting) begin
                xfer_count <= count_inc[8:0];
            end
            if (state == ST_DONE) begin
                rk_done <= 1'b1;
            end
            if (state == ST_ERROR) begin
                rk_done     <= 1'b1;
                rk_error    <= 1'b1;
                rk_err_code <= pend_code;
            end
        end
    end

endmodule
